// File: rtl/cci_mpf_csr_event_counters_if.sv
// Read request/response bundle between the MMIO CSR manager and the event-counter bank.
// Handshake: no ready; every cycle with rd_req_valid=1 is one accepted request, and its
// response appears as a single rd_rsp_valid=1 cycle exactly two clock edges later, in order.
interface cci_mpf_csr_event_counters_if #(
  parameter int IDX_WIDTH = 6,
  parameter int TID_WIDTH = 9
);
  logic                 rd_req_valid;
  logic [IDX_WIDTH-1:0] rd_req_idx;
  logic                 rd_req_shadow;
  logic [TID_WIDTH-1:0] rd_req_tid;
  logic                 rd_rsp_valid;
  logic [63:0]          rd_rsp_data;
  logic [TID_WIDTH-1:0] rd_rsp_tid;

  modport master (
    output rd_req_valid, rd_req_idx, rd_req_shadow, rd_req_tid,
    input  rd_rsp_valid, rd_rsp_data, rd_rsp_tid
  );

  modport slave (
    input  rd_req_valid, rd_req_idx, rd_req_shadow, rd_req_tid,
    output rd_rsp_valid, rd_rsp_data, rd_rsp_tid
  );
endinterface

// File: rtl/cci_mpf_csr_event_counters.sv
// Bank of saturating event counters with sticky overflow, clears, freeze, snapshot
// shadows and a fixed two-cycle indexed read port.
module cci_mpf_csr_event_counters #(
  parameter int N_EVENTS  = 16,
  parameter int CNT_WIDTH = 48,
  parameter int IDX_WIDTH = 6,
  parameter int TID_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_EVENTS-1:0]  event_in,
  input  logic                 freeze,
  input  logic                 clear_all,
  input  logic                 clear_idx_valid,
  input  logic [IDX_WIDTH-1:0] clear_idx,
  input  logic                 snap,
  cci_mpf_csr_event_counters_if.slave rd
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [N_EVENTS-1:0]  event_q;
  logic [CNT_WIDTH-1:0] cnt_q    [N_EVENTS];
  logic [CNT_WIDTH-1:0] cnt_d    [N_EVENTS];
  logic [CNT_WIDTH-1:0] shadow_q [N_EVENTS];
  logic [N_EVENTS-1:0]  ovf_q;
  logic [N_EVENTS-1:0]  ovf_d;
  logic [N_EVENTS-1:0]  shadow_ovf_q;

  logic                 s1_valid_q;
  logic [IDX_WIDTH-1:0] s1_idx_q;
  logic                 s1_shadow_q;
  logic [TID_WIDTH-1:0] s1_tid_q;
  logic [63:0]          rsp_data_d;
  logic                 rsp_valid_q;
  logic [63:0]          rsp_data_q;
  logic [TID_WIDTH-1:0] rsp_tid_q;

  // Clear beats increment, so an event coinciding with a clear is dropped.
  always_comb begin
    for (int i = 0; i < N_EVENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clear_all || (clear_idx_valid && (clear_idx == IDX_WIDTH'(i)))) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (event_q[i] && !freeze) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_q      <= '0;
      ovf_q        <= '0;
      shadow_ovf_q <= '0;
      for (int i = 0; i < N_EVENTS; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      event_q <= event_in;
      ovf_q   <= ovf_d;
      for (int i = 0; i < N_EVENTS; i++) cnt_q[i] <= cnt_d[i];
      // Snapshot takes pre-edge values, so snap+clear_all acts as read-and-reset.
      if (snap) begin
        shadow_ovf_q <= ovf_q;
        for (int i = 0; i < N_EVENTS; i++) shadow_q[i] <= cnt_q[i];
      end
    end
  end

  // Out-of-range indices match no counter and therefore read as zero.
  always_comb begin
    rsp_data_d = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      if (s1_idx_q == IDX_WIDTH'(i)) begin
        if (s1_shadow_q) begin
          rsp_data_d[CNT_WIDTH-1:0] = shadow_q[i];
          rsp_data_d[63]            = shadow_ovf_q[i];
        end else begin
          rsp_data_d[CNT_WIDTH-1:0] = cnt_q[i];
          rsp_data_d[63]            = ovf_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_shadow_q <= 1'b0;
      s1_tid_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tid_q   <= '0;
    end else begin
      s1_valid_q  <= rd.rd_req_valid;
      s1_idx_q    <= rd.rd_req_idx;
      s1_shadow_q <= rd.rd_req_shadow;
      s1_tid_q    <= rd.rd_req_tid;
      rsp_valid_q <= s1_valid_q;
      rsp_data_q  <= s1_valid_q ? rsp_data_d : 64'd0;
      rsp_tid_q   <= s1_valid_q ? s1_tid_q   : '0;
    end
  end

  assign rd.rd_rsp_valid = rsp_valid_q;
  assign rd.rd_rsp_data  = rsp_data_q;
  assign rd.rd_rsp_tid   = rsp_tid_q;

endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
// Randomised and directed bench for the event-counter bank; responses are checked by a
// monitor against a queue filled from a behavioural counter model.
module tb_cci_mpf_csr_event_counters;
  localparam int NE  = 16;
  localparam int CW  = 4;
  localparam int IW  = 6;
  localparam int TW  = 9;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset_n;
  logic [NE-1:0] event_in;
  logic          freeze;
  logic          clear_all;
  logic          clear_idx_valid;
  logic [IW-1:0] clear_idx;
  logic          snap;

  cci_mpf_csr_event_counters_if #(.IDX_WIDTH(IW), .TID_WIDTH(TW)) rd_if ();

  cci_mpf_csr_event_counters #(
    .N_EVENTS(NE), .CNT_WIDTH(CW), .IDX_WIDTH(IW), .TID_WIDTH(TW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .event_in(event_in), .freeze(freeze),
    .clear_all(clear_all), .clear_idx_valid(clear_idx_valid), .clear_idx(clear_idx),
    .snap(snap), .rd(rd_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [63:0]   exp_q[$];
  logic [TW-1:0] tid_q[$];
  int            due_q[$];
  logic [63:0]   last_data;
  logic [TW-1:0] last_tid;
  int            rsp_cnt = 0;
  logic [TW-1:0] tid_log[$];
  int            cyc_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cnt [NE];
  int          m_ovf [NE];
  int          m_shd [NE];
  int          m_sovf[NE];
  logic [NE-1:0] m_pipe;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        for (int i = 0; i < NE; i++) begin
          m_cnt[i] = 0; m_ovf[i] = 0; m_shd[i] = 0; m_sovf[i] = 0;
        end
        m_pipe = '0;
        exp_q.delete(); tid_q.delete(); due_q.delete();
      end else begin
        if (snap) begin
          for (int i = 0; i < NE; i++) begin
            m_shd[i] = m_cnt[i]; m_sovf[i] = m_ovf[i];
          end
        end
        for (int i = 0; i < NE; i++) begin
          if (clear_all || (clear_idx_valid && int'(clear_idx) == i)) begin
            m_cnt[i] = 0; m_ovf[i] = 0;
          end else if (m_pipe[i] && !freeze) begin
            if (m_cnt[i] == CMAX) m_ovf[i] = 1;
            else                  m_cnt[i] = m_cnt[i] + 1;
          end
        end
        m_pipe = event_in;
        if (rd_if.rd_req_valid) begin
          int idx;
          int c;
          int o;
          logic [63:0] e;
          idx = int'(rd_if.rd_req_idx);
          e = 64'd0;
          if (idx < NE) begin
            c = rd_if.rd_req_shadow ? m_shd[idx]  : m_cnt[idx];
            o = rd_if.rd_req_shadow ? m_sovf[idx] : m_ovf[idx];
            e = 64'(c) | ((o != 0) ? 64'h8000_0000_0000_0000 : 64'd0);
          end
          exp_q.push_back(e);
          tid_q.push_back(rd_if.rd_req_tid);
          due_q.push_back(cyc + 1);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_if.rd_rsp_valid) begin
        rsp_cnt++;
        last_data = rd_if.rd_rsp_data;
        last_tid  = rd_if.rd_rsp_tid;
        tid_log.push_back(rd_if.rd_rsp_tid);
        cyc_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_rsp: got valid with tid 0x%0h expected no response (cycle %0d)",
                   rd_if.rd_rsp_tid, cyc);
        end else begin
          chk("rsp_latency", 64'(cyc), 64'(due_q[0]));
          chk("rsp_data", rd_if.rd_rsp_data, exp_q[0]);
          chk("rsp_tid", 64'(rd_if.rd_rsp_tid), 64'(tid_q[0]));
          void'(exp_q.pop_front()); void'(tid_q.pop_front()); void'(due_q.pop_front());
        end
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        n_checks++; n_errors++;
        $display("FAIL missing_rsp: got no valid expected tid 0x%0h (cycle %0d)", tid_q[0], cyc);
        void'(exp_q.pop_front()); void'(tid_q.pop_front()); void'(due_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NE-1:0] ev, input logic frz, input logic ca,
                       input logic civ, input logic [IW-1:0] ci, input logic sn,
                       input logic rv, input logic [IW-1:0] ri, input logic rs,
                       input logic [TW-1:0] rt);
    event_in = ev; freeze = frz; clear_all = ca; clear_idx_valid = civ; clear_idx = ci;
    snap = sn; rd_if.rd_req_valid = rv; rd_if.rd_req_idx = ri; rd_if.rd_req_shadow = rs;
    rd_if.rd_req_tid = rt;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, 0, 0, 0, '0, 0, 0, '0, 0, '0);
  endtask

  task automatic pulse(input int bit_i, input int n, input logic frz);
    repeat (n) drive(NE'(1) << bit_i, frz, 0, 0, '0, 0, 0, '0, 0, '0);
  endtask

  task automatic rd(input logic [IW-1:0] idx, input logic sh, input logic [TW-1:0] tid);
    drive('0, 0, 0, 0, '0, 0, 1, idx, sh, tid);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int r0;
    reset_n = 1'b0;
    event_in = '0; freeze = 0; clear_all = 0; clear_idx_valid = 0; clear_idx = '0; snap = 0;
    rd_if.rd_req_valid = 0; rd_if.rd_req_idx = '0; rd_if.rd_req_shadow = 0; rd_if.rd_req_tid = '0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rd_if.rd_rsp_valid), 64'd0);
    chk("reset_rsp_data", rd_if.rd_rsp_data, 64'd0);
    chk("reset_rsp_tid", 64'(rd_if.rd_rsp_tid), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Reset with a read in flight: no response, counts wiped.
    pulse(0, 3, 0);
    idle(2);
    r0 = rsp_cnt;
    rd(0, 0, 9'h55);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(3);
    chk("reset_drops_read", 64'(rsp_cnt), 64'(r0));
    rd(0, 0, 9'h11);
    idle(1);
    chk("post_reset_zero", last_data, 64'd0);
    idle(1);

    // Count and latency.
    pulse(3, 5, 0);
    idle(2);
    c0 = cyc;
    rd(3, 0, 9'h1A3);
    idle(1);
    chk("count5_data", last_data, 64'd5);
    chk("count5_tid", 64'(last_tid), 64'h1A3);
    chk("count5_latency", 64'(cyc_log[$]), 64'(c0 + 2));

    // Saturation and per-index clear.
    pulse(0, 20, 0);
    idle(2);
    rd(0, 0, 9'd2);
    idle(1);
    chk("saturate", last_data, 64'h8000_0000_0000_000F);
    drive('0, 0, 0, 1, 6'd0, 0, 0, '0, 0, '0);
    rd(0, 0, 9'd3);
    idle(1);
    chk("clear_idx0", last_data, 64'd0);

    // Freeze discards events.
    drive(NE'(1) << 4, 1, 0, 0, '0, 0, 0, '0, 0, '0);
    pulse(4, 2, 1);
    drive('0, 1, 0, 0, '0, 0, 0, '0, 0, '0);
    idle(2);
    rd(4, 0, 9'd4);
    idle(1);
    chk("freeze", last_data, 64'd0);

    // clear_all races a pending increment.
    pulse(2, 2, 0);
    pulse(2, 1, 0);
    drive('0, 0, 1, 0, '0, 0, 0, '0, 0, '0);
    idle(2);
    rd(2, 0, 9'd5);
    idle(1);
    chk("clear_race", last_data, 64'd0);

    // Out-of-range per-index clears change nothing.
    pulse(5, 3, 0);
    idle(2);
    drive('0, 0, 0, 1, 6'd16, 0, 0, '0, 0, '0);
    drive('0, 0, 0, 1, 6'd63, 0, 0, '0, 0, '0);
    rd(5, 0, 9'd6);
    idle(1);
    chk("clear_oor", last_data, 64'd3);

    // Snap with clear_all is read-and-reset.
    pulse(1, 7, 0);
    idle(2);
    drive('0, 0, 1, 0, '0, 1, 0, '0, 0, '0);
    pulse(1, 2, 0);
    idle(2);
    rd(1, 1, 9'd7);
    idle(1);
    chk("snap_shadow", last_data, 64'd7);
    rd(1, 0, 9'd8);
    idle(1);
    chk("snap_live", last_data, 64'd2);

    // Back-to-back reads.
    r0 = rsp_cnt;
    for (int i = 0; i < 4; i++) rd(IW'(i), 0, TW'(i + 1));
    idle(2);
    chk("b2b_count", 64'(rsp_cnt - r0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_tid_order", 64'(tid_log[tid_log.size() - 4 + i]), 64'(i + 1));
      chk("b2b_consecutive", 64'(cyc_log[cyc_log.size() - 4 + i] - cyc_log[cyc_log.size() - 4]),
          64'(i));
    end
    rd(6'd63, 0, 9'd9);
    idle(1);
    chk("idx63_data", last_data, 64'd0);
    chk("idx63_tid", 64'(last_tid), 64'd9);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      drive(NE'($urandom & $urandom & $urandom),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 14) == 0), IW'($urandom_range(0, 19)),
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 1) == 1), IW'($urandom_range(0, 19)),
            ($urandom_range(0, 1) == 1), TW'($urandom));
    end
    idle(4);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cci_mpf_csr_event_counters.md
Name: cci_mpf_csr_event_counters

Overview:
- Parametrised event-counter bank behind the MPF CSR manager; replaces per-shim ad hoc summing of 1-cycle event wires (VTP hit/miss, WRO conflicts, PWRITE, VC map change).
- Counts N_EVENTS pulse inputs in saturating counters with sticky overflow.
- Supports global and per-index clear, freeze, and an atomic snapshot into shadow registers.
- Serves indexed reads with fixed 2-cycle latency to the MMIO response path.

Parameters:
- N_EVENTS, 16, number of event inputs/counters (1..64).
- CNT_WIDTH, 48, counter width in bits (1..63).
- IDX_WIDTH, 6, width of read/clear index; must satisfy 2**IDX_WIDTH >= N_EVENTS.
- TID_WIDTH, 9, width of read transaction tag (MMIO tid).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- event_in  in  N_EVENTS  one bit per event; each high cycle is +1.
- freeze  in  1  level; while high, counting is suspended.
- clear_all  in  1  pulse; zero all counters and overflow bits.
- clear_idx_valid  in  1  pulse; zero the counter selected by clear_idx.
- clear_idx  in  IDX_WIDTH  counter to clear.
- snap  in  1  pulse; copy all live counters and overflow bits to shadow.
- rd_req_valid  in  1  read request.
- rd_req_idx  in  IDX_WIDTH  counter index.
- rd_req_shadow  in  1  1 = read shadow copy, 0 = read live counter.
- rd_req_tid  in  TID_WIDTH  tag returned with the response.
- rd_rsp_valid  out  1  response valid, one cycle.
- rd_rsp_data  out  64  [63] = overflow, [CNT_WIDTH-1:0] = count, others 0.
- rd_rsp_tid  out  TID_WIDTH  echoed tag.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All counters, overflow bits, shadows and the event_q register go to 0.
  - rd_rsp_valid, rd_rsp_data and rd_rsp_tid go to 0.
  - Any in-flight read is dropped and produces no response after reset is released.
- Event pipeline:
  - event_in is registered into event_q at edge k.
  - Counter i increments at edge k+1 when event_q[i]=1 and freeze=0 in the cycle before edge k+1.
  - Events are therefore visible 2 edges after assertion.
  - Events arriving while freeze is high are discarded, not deferred.
- Saturation:
  - A counter at all-ones that receives an increment stays at all-ones and sets its sticky overflow bit.
  - Only clear_all or a matching per-index clear resets the overflow bit.
- Clear priority, per counter per edge: clear_all > matching clear_idx_valid > increment.
  - A clear in the same cycle as a pending event_q increment yields 0; the event is lost.
  - A clear_idx >= N_EVENTS is ignored.
- Snapshot:
  - At the edge where snap=1, shadow[i] takes the live counter value held before that edge; the same-edge increment is excluded.
  - snap together with clear_all: shadow captures the pre-clear values and live counters become 0. This is the required "read-and-reset" idiom.
- Read pipeline, fixed latency 2, no backpressure, one request per cycle accepted:
  - Stage 1 registers idx, shadow and tid at edge k.
  - Stage 2 registers the muxed data at edge k+1.
  - rd_rsp_valid is high for exactly one cycle, after edge k+1.
  - Data returned is the value present after edge k, i.e. it includes updates applied at edge k.
  - Back-to-back requests produce back-to-back responses, in order.
  - rd_req_idx >= N_EVENTS returns data 0 with valid and tid as normal.
- Arithmetic:
  - Counters are unsigned CNT_WIDTH bits.
  - Response bits [62:CNT_WIDTH] are zero.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-read: rd_req_valid=1 at idx 0, then reset_n low 1 cycle later -> rd_rsp_valid stays 0 through and after reset; every read returns 0.
- Count and latency: pulse event_in[3] for 5 cycles, then read idx 3 live -> rd_rsp_valid exactly 2 edges after the request; data=5; tid echoed; bit 63=0.
- Saturation (CNT_WIDTH=4): pulse event_in[0] 20 times, read -> data[3:0]=0xF and bit 63=1. Then clear_idx_valid with idx 0 and read -> data=0.
- Freeze and clear race:
  - 3 events with freeze=1 -> count 0.
  - clear_all in the same cycle event_q[2]=1 -> counter 2 reads 0.
  - Out-of-range clear_idx=N_EVENTS -> no counter changes.
- Snap+clear: counter 1 = 7, assert snap and clear_all together, then 2 events -> shadow read 7; live read 2.
- Throughput: 4 back-to-back reads with idx 0..3 and tids 1..4 -> 4 consecutive response cycles in tid order 1..4; idx 63 (out of range) -> data 0.
